// File: rtl/grid_access_arbiter_pkg.sv
// Shared placement definitions: op encodings, arbiter FSM states and the
// free-cell marker used by claim operations and the placement datapath.
package grid_access_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLAIM = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_CLAIM_CHK = 3'd3,
    ST_CLAIM_WR  = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  // A grid cell holding this value is free and may be claimed.
  localparam int EMPTY_CELL = -1;

  // Round-robin successor of idx among n requesters.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/grid_access_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant to the first valid
// requester at or after ptr, wrapping past the top index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  int               idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  // Scan from ptr upwards and keep only the first valid hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = PTR_W'(idx);
      if (!found && valid[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter giving N_REQ requesters serialized access to one
// single-port grid RAM (1-cycle registered read). Supports read, write and
// an atomic claim (write only if the cell holds EMPTY).
// Handshake: req_ready is a one-hot combinational strobe, high only in IDLE
// for the granted requester; valid & ready in a cycle is the accept, and a
// requester holds valid and payload steady until it sees its ready.
// rsp_valid is a single-cycle pulse with no backpressure.
module grid_access_arbiter
  import grid_access_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int EMPTY  = EMPTY_CELL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [2*N_REQ-1:0]       req_op,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_ok,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int                PTR_W   = $clog2(N_REQ);
  localparam logic [DATA_W-1:0] EMPTY_V = DATA_W'(EMPTY);

  state_e              state, state_nx;
  logic [PTR_W-1:0]    rr_ptr;
  logic [N_REQ-1:0]    grant;
  logic                accept;

  logic [2:0]          pick_id;
  op_e                 pick_op;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  op_e                 lat_op;
  logic [2:0]          lat_id;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   res_data;
  logic                res_ok;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign accept = (state == ST_IDLE) && (|grant);

  // Extract the granted requester's payload from the packed request buses.
  always_comb begin
    pick_id    = '0;
    pick_op    = OP_READ;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        pick_id    = 3'(i);
        pick_op    = op_e'(req_op[2*i +: 2]);
        pick_addr  = req_addr[ADDR_W*i +: ADDR_W];
        pick_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and all outputs; everything idles low while reset is held so
  // an aborted operation neither responds nor touches memory.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_ok    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          req_ready = grant;
          if (accept) state_nx = (pick_op == OP_RSVD) ? ST_RESP : ST_ISSUE;
        end
        ST_ISSUE: begin
          mem_addr = lat_addr;
          if (lat_op == OP_WRITE) begin
            mem_write = 1'b1;
            mem_wdata = lat_wdata;
            state_nx  = ST_RESP;
          end else begin
            mem_read = 1'b1;
            state_nx = (lat_op == OP_CLAIM) ? ST_CLAIM_CHK : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT:   state_nx = ST_RESP;
        ST_CLAIM_CHK: state_nx = (mem_rdata == EMPTY_V) ? ST_CLAIM_WR : ST_RESP;
        ST_CLAIM_WR: begin
          mem_write = 1'b1;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
          state_nx  = ST_RESP;
        end
        ST_RESP: begin
          rsp_valid = 1'b1;
          rsp_id    = lat_id;
          rsp_data  = res_data;
          rsp_ok    = res_ok;
          state_nx  = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Request latch, round-robin pointer and response result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      lat_op    <= OP_READ;
      lat_id    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      res_data  <= '0;
      res_ok    <= 1'b0;
    end else begin
      if (accept) begin
        lat_op    <= pick_op;
        lat_id    <= pick_id;
        lat_addr  <= pick_addr;
        lat_wdata <= pick_wdata;
        rr_ptr    <= PTR_W'(wrap_next(int'(pick_id), N_REQ));
        // Writes answer with the written value; reserved ops with 0 / fail.
        res_data  <= (pick_op == OP_WRITE) ? pick_wdata : '0;
        res_ok    <= (pick_op == OP_WRITE);
      end
      if (state == ST_RD_WAIT) begin
        res_data <= mem_rdata;
        res_ok   <= 1'b1;
      end
      if (state == ST_CLAIM_CHK) begin
        if (mem_rdata == EMPTY_V) begin
          res_data <= lat_wdata;
          res_ok   <= 1'b1;
        end else begin
          res_data <= mem_rdata;
          res_ok   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Bench for grid_access_arbiter: a RAM model, a transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_grid_access_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] EMPTY_V = '1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_init = 1'b1;

  logic [N_REQ-1:0]        req_valid = '0;
  logic [1:0]              op_a   [N_REQ];
  logic [ADDR_W-1:0]       addr_a [N_REQ];
  logic [DATA_W-1:0]       data_a [N_REQ];
  logic [2*N_REQ-1:0]      req_op;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;

  logic [N_REQ-1:0]  req_ready;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ok;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  grid_access_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EMPTY(-1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ok(rsp_ok),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Pack per-requester payloads onto the DUT buses
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_op[2*i +: 2]              = op_a[i];
      req_addr[ADDR_W*i +: ADDR_W]  = addr_a[i];
      req_wdata[DATA_W*i +: DATA_W] = data_a[i];
    end
  end

  // Single-port RAM with registered read
  logic [DATA_W-1:0] ram [1<<ADDR_W];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1<<ADDR_W); i++) ram[i] <= EMPTY_V;
    end else if (mem_write) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_read) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // Reference model: one transaction at a time, described by the cycle
  // offsets (from accept) at which it reads, writes and responds.
  int                m_ptr = 0;
  bit                m_busy = 1'b0;
  int                m_rel = 0, m_rd_at = -1, m_wr_at = -1, m_rsp_at = -1, m_id = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_rsp_data = '0;
  logic              m_rsp_ok = 1'b0;
  logic [DATA_W-1:0] ref_grid [1<<ADDR_W];

  // Compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_ready;
    logic             exp_rd, exp_wr, exp_rsp;
    logic [1:0]       g_op;
    int               g;
    if (ram_init) for (int i = 0; i < (1<<ADDR_W); i++) ref_grid[i] = EMPTY_V;
    if (reset) begin
      chk("reset_ready", 32'(req_ready), 0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_mem_read", 32'(mem_read), 0);
      chk("reset_mem_write", 32'(mem_write), 0);
      m_busy = 1'b0;
      m_ptr  = 0;
    end else begin
      exp_ready = '0;
      g = -1;
      if (m_busy) m_rel++;
      else begin
        for (int k = 0; k < N_REQ; k++)
          if (g < 0 && req_valid[2'((m_ptr + k) % N_REQ)]) g = (m_ptr + k) % N_REQ;
      end
      if (g >= 0) exp_ready[2'(g)] = 1'b1;
      exp_rd  = m_busy && (m_rel == m_rd_at);
      exp_wr  = m_busy && (m_rel == m_wr_at);
      exp_rsp = m_busy && (m_rel == m_rsp_at);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("mem_read", 32'(mem_read), 32'(exp_rd));
      chk("mem_write", 32'(mem_write), 32'(exp_wr));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rd || exp_wr) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (exp_wr) begin
        chk("mem_wdata", mem_wdata, m_wdata);
        ref_grid[m_addr] = m_wdata;
      end
      if (exp_rsp) begin
        chk("rsp_id", 32'(rsp_id), m_id);
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_ok", 32'(rsp_ok), 32'(m_rsp_ok));
        m_busy = 1'b0;
      end
      if (g >= 0) begin
        g_op    = op_a[2'(g)];
        m_addr  = addr_a[2'(g)];
        m_wdata = data_a[2'(g)];
        m_id    = g;
        m_ptr   = (g + 1) % N_REQ;
        m_busy  = 1'b1;
        m_rel   = 0;
        case (g_op)
          2'b00: begin m_rd_at = 1; m_wr_at = -1; m_rsp_at = 3; m_rsp_data = ref_grid[m_addr]; m_rsp_ok = 1'b1; end
          2'b01: begin m_rd_at = -1; m_wr_at = 1; m_rsp_at = 2; m_rsp_data = m_wdata; m_rsp_ok = 1'b1; end
          2'b10: begin
            m_rd_at = 1;
            if (ref_grid[m_addr] == EMPTY_V) begin
              m_wr_at = 3; m_rsp_at = 4; m_rsp_data = m_wdata; m_rsp_ok = 1'b1;
            end else begin
              m_wr_at = -1; m_rsp_at = 3; m_rsp_data = ref_grid[m_addr]; m_rsp_ok = 1'b0;
            end
          end
          default: begin m_rd_at = -1; m_wr_at = -1; m_rsp_at = 1; m_rsp_data = '0; m_rsp_ok = 1'b0; end
        endcase
      end
    end
  end

  // Driver: issue one request and record cycle offsets relative to accept
  task automatic do_req(input int id, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, output int t_grant, output int t_rd,
                        output int t_wr, output int t_rsp, output int r_id,
                        output logic [DATA_W-1:0] r_data, output logic r_ok);
    int rel;
    rel = -1; t_grant = -1; t_rd = -1; t_wr = -1; t_rsp = -1; r_id = -1; r_data = '0; r_ok = 1'b0;
    @(posedge clk); #1;
    op_a[2'(id)] = op; addr_a[2'(id)] = addr; data_a[2'(id)] = data;
    req_valid[2'(id)] = 1'b1;
    for (int k = 0; k < 12 && t_rsp < 0; k++) begin
      @(negedge clk);
      if (rel < 0 && req_ready[2'(id)]) begin rel = 0; t_grant = k; end
      else if (rel >= 0) rel++;
      if (rel >= 0) begin
        if (mem_read && t_rd < 0) t_rd = rel;
        if (mem_write && t_wr < 0) t_wr = rel;
        if (rsp_valid) begin t_rsp = rel; r_id = int'(rsp_id); r_data = rsp_data; r_ok = rsp_ok; end
      end
      @(posedge clk); #1;
      if (rel == 0) req_valid[2'(id)] = 1'b0;
    end
    req_valid[2'(id)] = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int tg, trd, twr, trsp, rid, rel, first;
    logic [DATA_W-1:0] rdat;
    logic rok, saw_rsp, saw_wr;
    int order[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N_REQ; i++) begin op_a[i] = 2'b00; addr_a[i] = '0; data_a[i] = '0; end

    // Reset with grid initialised to EMPTY
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; ram_init = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_id", 32'(rsp_id), 0);
    chk("post_reset_rsp_data", rsp_data, 0);
    chk("post_reset_rsp_ok", 32'(rsp_ok), 0);
    chk("post_reset_mem_addr", 32'(mem_addr), 0);
    chk("post_reset_mem_wdata", mem_wdata, 0);

    // req0 write addr 5 data 7
    do_req(0, 2'b01, 4'd5, 32'd7, tg, trd, twr, trsp, rid, rdat, rok);
    chk("wr_grant_cycle", tg, 0);
    chk("wr_mem_write_cycle", twr, 1);
    chk("wr_no_read", trd, -1);
    chk("wr_rsp_cycle", trsp, 2);
    chk("wr_rsp_id", rid, 0);
    chk("wr_rsp_ok", 32'(rok), 1);
    chk("wr_rsp_data", rdat, 7);

    // req1 read addr 5
    do_req(1, 2'b00, 4'd5, 32'd0, tg, trd, twr, trsp, rid, rdat, rok);
    chk("rd_grant_cycle", tg, 0);
    chk("rd_mem_read_cycle", trd, 1);
    chk("rd_no_write", twr, -1);
    chk("rd_rsp_cycle", trsp, 3);
    chk("rd_rsp_id", rid, 1);
    chk("rd_rsp_data", rdat, 7);
    chk("rd_rsp_ok", 32'(rok), 1);

    // req2 claim free cell 3
    do_req(2, 2'b10, 4'd3, 32'd9, tg, trd, twr, trsp, rid, rdat, rok);
    chk("claim_read_cycle", trd, 1);
    chk("claim_write_cycle", twr, 3);
    chk("claim_rsp_cycle", trsp, 4);
    chk("claim_rsp_id", rid, 2);
    chk("claim_rsp_ok", 32'(rok), 1);
    chk("claim_rsp_data", rdat, 9);

    // req3 claims the same cell: rejected with the occupant
    do_req(3, 2'b10, 4'd3, 32'd11, tg, trd, twr, trsp, rid, rdat, rok);
    chk("reclaim_rsp_cycle", trsp, 3);
    chk("reclaim_rsp_id", rid, 3);
    chk("reclaim_rsp_ok", 32'(rok), 0);
    chk("reclaim_rsp_data", rdat, 9);
    chk("reclaim_no_write", twr, -1);
    chk("reclaim_ram_cell", ram[3], 9);

    // req1 reserved op
    do_req(1, 2'b11, 4'd2, 32'd55, tg, trd, twr, trsp, rid, rdat, rok);
    chk("rsvd_rsp_cycle", trsp, 1);
    chk("rsvd_rsp_id", rid, 1);
    chk("rsvd_rsp_ok", 32'(rok), 0);
    chk("rsvd_rsp_data", rdat, 0);
    chk("rsvd_no_read", trd, -1);
    chk("rsvd_no_write", twr, -1);

    // All four valid continuously from reset: grant order 0,1,2,3,0
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = 2'b01; addr_a[i] = ADDR_W'(8 + i); data_a[i] = DATA_W'(100 + i);
    end
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 40 && order.size() < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) if (req_ready[2'(i)]) order.push_back(i);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (6) @(posedge clk);
    chk("rr_grant_count", order.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) chk($sformatf("rr_grant_%0d", k), order[k], exp_order[k]);

    // Reset while a claim on a free cell sits in CLAIM_CHK
    @(posedge clk); #1;
    op_a[2] = 2'b10; addr_a[2] = 4'd4; data_a[2] = 32'd5;
    req_valid[2] = 1'b1;
    rel = -1;
    for (int k = 0; k < 12 && rel < 1; k++) begin
      @(negedge clk);
      if (rel < 0 && req_ready[2]) rel = 0;
      else if (rel >= 0) rel++;
      @(posedge clk); #1;
      if (rel == 0) req_valid[2] = 1'b0;
    end
    req_valid[2] = 1'b0;
    chk("abort_claim_granted", rel, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    saw_rsp = 1'b0; saw_wr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      if (mem_write) saw_wr = 1'b1;
    end
    chk("abort_no_rsp", 32'(saw_rsp), 0);
    chk("abort_no_write", 32'(saw_wr), 0);
    chk("abort_cell_free", ram[4], EMPTY_V);

    // Next grant after reset goes to requester 0
    @(posedge clk); #1;
    op_a[0] = 2'b01; addr_a[0] = 4'd12; data_a[0] = 32'd21;
    op_a[3] = 2'b01; addr_a[3] = 4'd13; data_a[3] = 32'd22;
    req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    first = -1;
    for (int k = 0; k < 10 && first < 0; k++) begin
      @(negedge clk);
      for (int i = N_REQ - 1; i >= 0; i--) if (req_ready[2'(i)]) first = i;
    end
    @(posedge clk); #1 req_valid = '0;
    chk("post_abort_first_grant", first, 0);
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
